// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: digit scan divider, frame-synchronous double buffer for
// hex/point/blank vectors, and per-digit blink generator for a 4-digit display.
module display_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] hexs_in,
    input  logic [3:0]  points_in,
    input  logic [3:0]  LEs_in,
    input  logic [3:0]  blink_in,
    input  logic        load,
    output logic [1:0]  scan,
    output logic [15:0] hexs,
    output logic [3:0]  points,
    output logic [3:0]  LEs,
    output logic        frame_start,
    output logic        pending
);

    localparam int unsigned DIV_W  = 32;
    localparam int unsigned FRM_W  = 16;
    localparam int unsigned HEX_W  = 16;
    localparam int unsigned DIG_N  = 4;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRAME_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [FRM_W-1:0] frame_cnt;
    logic             blink_phase;

    logic [HEX_W-1:0] pend_hexs;
    logic [DIG_N-1:0] pend_points;
    logic [DIG_N-1:0] pend_les;
    logic [DIG_N-1:0] pend_blink;

    logic [DIG_N-1:0] shadow_les;
    logic [DIG_N-1:0] shadow_blink;

    logic tick;
    logic boundary;

    // Last cycle of a digit slot, and last cycle of a whole frame.
    assign tick     = (div_cnt == DIV_LAST);
    assign boundary = tick && (scan == 2'd3);

    // Clock divider producing the digit scan index.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            scan    <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            scan    <= scan + 2'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Frame-start pulse: the first cycle of scan==0 in each new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary;
        end
    end

    // Blink half-period counter in whole frames; phase only moves on a boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (boundary) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FRM_W'(1);
            end
        end
    end

    // Double buffer: loads park in the pending buffers until the frame boundary,
    // except a load on the boundary cycle itself, which goes straight through.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_hexs    <= '0;
            pend_points  <= '0;
            pend_les     <= '0;
            pend_blink   <= '0;
            pending      <= 1'b0;
            hexs         <= '0;
            points       <= '0;
            shadow_les   <= '1;
            shadow_blink <= '0;
        end else if (load) begin
            pend_hexs   <= hexs_in;
            pend_points <= points_in;
            pend_les    <= LEs_in;
            pend_blink  <= blink_in;
            if (boundary) begin
                pending      <= 1'b0;
                hexs         <= hexs_in;
                points       <= points_in;
                shadow_les   <= LEs_in;
                shadow_blink <= blink_in;
            end else begin
                pending <= 1'b1;
            end
        end else if (boundary && pending) begin
            pending      <= 1'b0;
            hexs         <= pend_hexs;
            points       <= pend_points;
            shadow_les   <= pend_les;
            shadow_blink <= pend_blink;
        end
    end

    // Blinking digits are blanked during the active blink phase.
    assign LEs = shadow_les | (shadow_blink & {DIG_N{blink_phase}});

endmodule
